// File: rtl/im_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// the byte/checksum geometry used by the packer and the top level.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream handshake plus the IM write port driven by the loader.
// The master side feeds bytes and watches the writes; the slave is the loader.
interface im_loader_if #(
  parameter int bit_size = 32,
  parameter int mem_size = 16
);

  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic                IM_wr_en;
  logic [mem_size-1:0] IM_wr_addr;
  logic [bit_size-1:0] IM_wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, IM_wr_en, IM_wr_addr, IM_wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, IM_wr_en, IM_wr_addr, IM_wr_data
  );

endinterface

// File: rtl/im_loader_byte_packer.sv
// Packs accepted stream bytes MSB first into instruction words; word and
// word_valid are combinational so the top can register the word on the 4th byte's edge.
module byte_packer
  import loader_pkg::*;
#(
  parameter int bit_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                byte_stb,
  input  logic [7:0]          in_data,
  output logic [bit_size-1:0] word,
  output logic                word_valid
);

  localparam int HOLD_W = bit_size - 8;

  logic [1:0]        byte_cnt;
  logic [HOLD_W-1:0] hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt <= '0;
      hold     <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      hold     <= '0;
    end else if (byte_stb) begin
      byte_cnt <= byte_cnt + 2'd1;
      hold     <= {hold[HOLD_W-9:0], in_data};
    end
  end

  // The current byte completes the word without waiting for it to be stored.
  assign word       = {hold, in_data};
  assign word_valid = byte_stb && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/im_loader.sv
// Program loader: streams bytes into IM as 32-bit words, checks a trailing
// checksum, and holds the CPU in reset until a load completes cleanly.
module im_loader
  import loader_pkg::*;
#(
  parameter int bit_size = 32,
  parameter int mem_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [mem_size-1:0] len,
  im_loader_if.slave          bus,
  output logic                cpu_rst,
  output logic                busy,
  output logic                done,
  output logic                load_err
);

  state_t              state;
  state_t              next_state;
  logic [mem_size-1:0] len_q;
  logic [mem_size-1:0] word_cnt;
  logic [mem_size-1:0] last_idx;
  logic [CSUM_W-1:0]   sum;
  logic                fire;
  logic                start_load;
  logic                byte_stb;
  logic [bit_size-1:0] word;
  logic                word_valid;

  assign fire       = bus.in_valid && bus.in_ready;
  assign start_load = start && (state == IDLE || state == DONE || state == ERR);
  assign byte_stb   = fire && (state == LOAD);
  assign last_idx   = len_q - mem_size'(1);

  byte_packer #(.bit_size(bit_size)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_load),
    .byte_stb   (byte_stb),
    .in_data    (bus.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (start) next_state = (len == '0) ? DONE : LOAD;
      LOAD:            if (word_valid && word_cnt == last_idx) next_state = CHECK;
      CHECK:           if (fire) next_state = (bus.in_data == sum) ? DONE : ERR;
      default:         next_state = IDLE;
    endcase
  end

  // Status outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.in_ready <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      load_err     <= 1'b0;
      cpu_rst      <= 1'b1;
    end else begin
      bus.in_ready <= (next_state == LOAD) || (next_state == CHECK);
      busy         <= (next_state == LOAD) || (next_state == CHECK);
      done         <= (next_state == DONE);
      load_err     <= (next_state == ERR);
      cpu_rst      <= (next_state != DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q          <= '0;
      word_cnt       <= '0;
      sum            <= '0;
      bus.IM_wr_en   <= 1'b0;
      bus.IM_wr_addr <= '0;
      bus.IM_wr_data <= '0;
    end else begin
      bus.IM_wr_en <= word_valid;
      if (start_load) begin
        len_q    <= len;
        word_cnt <= '0;
        sum      <= '0;
      end else begin
        if (byte_stb) sum <= sum + bus.in_data;
        if (word_valid) begin
          bus.IM_wr_addr <= word_cnt;
          bus.IM_wr_data <= word;
          word_cnt       <= word_cnt + mem_size'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: good/bad checksum loads, stalls, ignored
// start, zero-length load and mid-load reset abort, with hand-computed expectations.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        load_err;

  int n_checks    = 0;
  int n_fail      = 0;
  int write_count = 0;
  int exp_writes  = 0;

  logic [7:0]  stream    [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
  logic [31:0] exp_words [2] = '{32'h12345678, 32'h9ABCDEF0};

  im_loader_if #(.bit_size(32), .mem_size(16)) bus ();

  im_loader #(.bit_size(32), .mem_size(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .bus      (bus),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.IM_wr_en === 1'b1) write_count++;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] n);
    start = 1'b1;
    len   = n;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int guard = 0;
    if (stall) begin
      bus.in_valid = 1'b0;
      step();
    end
    while (bus.in_ready !== 1'b1 && guard < 16) begin
      step();
      guard++;
    end
    check_output("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Full two-word load; poke drops a start pulse with a different len mid-word.
  task automatic apply_stimulus(input logic [7:0] csum, input bit stall, input bit poke, input bit exp_ok);
    pulse_start(16'd2);
    check_output("busy_after_start", 32'(busy), 32'd1);
    check_output("cpu_rst_after_start", 32'(cpu_rst), 32'd1);
    check_output("done_after_start", 32'(done), 32'd0);
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(stream[w*4+k], stall);
        if (k < 3) check_output("wr_en_between", 32'(bus.IM_wr_en), 32'd0);
        if (poke && w == 0 && k == 1) begin
          pulse_start(16'd5);
          check_output("busy_after_poke", 32'(busy), 32'd1);
        end
      end
      check_output("wr_en_pulse", 32'(bus.IM_wr_en), 32'd1);
      check_output("wr_addr", 32'(bus.IM_wr_addr), 32'(w));
      check_output("wr_data", bus.IM_wr_data, exp_words[w]);
      exp_writes++;
    end
    check_output("busy_in_check", 32'(busy), 32'd1);
    check_output("done_in_check", 32'(done), 32'd0);
    send_byte(csum, stall);
    check_output("done_final", 32'(done), 32'(exp_ok));
    check_output("load_err_final", 32'(load_err), 32'(!exp_ok));
    check_output("cpu_rst_final", 32'(cpu_rst), 32'(!exp_ok));
    check_output("busy_final", 32'(busy), 32'd0);
    check_output("in_ready_final", 32'(bus.in_ready), 32'd0);
    check_output("wr_en_final", 32'(bus.IM_wr_en), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) step();
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("rst_wr_en", 32'(bus.IM_wr_en), 32'd0);
    check_output("rst_wr_addr", 32'(bus.IM_wr_addr), 32'd0);
    check_output("rst_wr_data", bus.IM_wr_data, 32'd0);
    check_output("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_load_err", 32'(load_err), 32'd0);

    rst = 1'b1;
    repeat (3) step();
    $display("[TB] reset released, idle");
    check_output("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    check_output("idle_busy", 32'(busy), 32'd0);
    check_output("idle_done", 32'(done), 32'd0);
    check_output("idle_in_ready", 32'(bus.in_ready), 32'd0);

    $display("[TB] zero-length load");
    pulse_start(16'd0);
    check_output("len0_done", 32'(done), 32'd1);
    check_output("len0_cpu_rst", 32'(cpu_rst), 32'd0);
    check_output("len0_busy", 32'(busy), 32'd0);
    check_output("len0_wr_en", 32'(bus.IM_wr_en), 32'd0);
    step();
    check_output("len0_writes", 32'(write_count), 32'(exp_writes));

    $display("[TB] good load");
    apply_stimulus(8'h38, 1'b0, 1'b0, 1'b1);
    $display("[TB] bad checksum");
    apply_stimulus(8'h39, 1'b0, 1'b0, 1'b0);
    $display("[TB] reload from error");
    apply_stimulus(8'h38, 1'b0, 1'b0, 1'b1);
    $display("[TB] stalled stream");
    apply_stimulus(8'h38, 1'b1, 1'b0, 1'b1);
    $display("[TB] start pulse mid-load");
    apply_stimulus(8'h38, 1'b0, 1'b1, 1'b1);

    $display("[TB] reset abort after 5 bytes");
    pulse_start(16'd2);
    for (int i = 0; i < 5; i++) begin
      send_byte(stream[i], 1'b0);
      if (i == 3) begin
        check_output("abort_wr0_en", 32'(bus.IM_wr_en), 32'd1);
        check_output("abort_wr0_data", bus.IM_wr_data, exp_words[0]);
        exp_writes++;
      end
    end
    rst = 1'b0;
    #1;
    check_output("abort_wr_en", 32'(bus.IM_wr_en), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    check_output("abort_wr_addr", 32'(bus.IM_wr_addr), 32'd0);
    repeat (3) step();
    rst = 1'b1;
    step();
    check_output("abort_writes", 32'(write_count), 32'(exp_writes));

    $display("[TB] good load after abort");
    apply_stimulus(8'h38, 1'b0, 1'b0, 1'b1);
    step();
    check_output("total_writes", 32'(write_count), 32'(exp_writes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Program loader that fills the single-cycle CPU's instruction memory (IM) before execution; it is the write side of the IM that `top` only reads.
- Accepts a byte stream through a valid/ready handshake and packs every 4 bytes into a 32-bit instruction word.
- Writes the words to IM at consecutive word addresses, then verifies a trailing checksum byte.
- Holds the CPU in reset until the load completes successfully.

Parameters:
- bit_size, 32, instruction word width; fixed at 4 bytes per word.
- mem_size, 16, IM address width in words; also the width of len.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; sampled in IDLE, DONE and ERR.
- len  input  mem_size  number of words to load; sampled on start.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- IM_wr_en  output  1  IM write strobe, one cycle per word.
- IM_wr_addr  output  mem_size  IM word address.
- IM_wr_data  output  bit_size  instruction word.
- cpu_rst  output  1  active-high reset to `top`; asserted while not DONE.
- busy  output  1  high in LOAD and CHECK.
- done  output  1  high in DONE.
- load_err  output  1  high in ERR.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; in_ready=0, IM_wr_en=0, IM_wr_addr=0, IM_wr_data=0.
  - cpu_rst=1, busy=0, done=0, load_err=0.
  - Internal byte counter, word counter, packing register and running sum all cleared.
- All outputs are registered.
- A byte transfer occurs on a rising edge where in_valid && in_ready.
- States: IDLE, LOAD, CHECK, DONE, ERR.
- IDLE:
  - in_ready=0, cpu_rst=1.
  - start with len!=0 → LOAD; latch len, clear the counters, sum=0.
  - start with len==0 → DONE on the next edge, with no writes.
- LOAD:
  - in_ready=1 continuously.
  - Bytes are packed MSB first: 1st byte → [31:24], then [23:16], [15:8], and the 4th byte → [7:0].
  - Each accepted byte is added into an 8-bit sum, mod 256 with wrap-around.
  - On the edge that accepts the 4th byte of a word, the full word is loaded into IM_wr_data, IM_wr_addr is set to the word index, and IM_wr_en is asserted.
  - Latency is therefore 1 cycle after the 4th byte is accepted; IM_wr_en stays high for exactly 1 cycle.
  - The word index increments after each write; the first word goes to address 0.
  - A byte may be accepted in the same cycle a write is presented, so there is no bubble and back-to-back words are allowed.
  - After the 4th byte of word len-1 → CHECK.
  - in_valid gaps simply stall progress; there is no timeout.
- CHECK:
  - in_ready=1; the next accepted byte is the checksum and is not added to the sum.
  - Checksum equal to sum → DONE; otherwise → ERR.
- DONE:
  - done=1, cpu_rst=0, in_ready=0.
  - start → LOAD (reload); the CPU is put back in reset on the same edge.
- ERR:
  - load_err=1, cpu_rst=1, in_ready=0.
  - Exits only on start (→ LOAD per the IDLE rules) or on reset.
- start in LOAD or CHECK is ignored.
- Reset mid-load aborts immediately:
  - The partial word is discarded and no write is issued.
  - Words already written stay in IM and are not cleaned up.
- len=2^mem_size-1 is the largest load; IM_wr_addr never wraps within a load.

Decomposition:
- Shared package loader_pkg holds:
  - the state encoding (IDLE=0, LOAD=1, CHECK=2, DONE=3, ERR=4, 3 bits);
  - BYTES_PER_WORD=4;
  - CSUM_W=8.
- One sub-module, byte_packer:
  - inputs: byte strobe and in_data;
  - outputs: packed word and a word_valid pulse;
  - keeps a 2-bit byte counter, clears on the FSM's clear.
- The top level holds the FSM, word counter, checksum and output registers.

Test Plan:
- Reset values: hold rst=0 → all outputs at the reset values with cpu_rst=1. Release rst, no start → nothing changes.
- Good load: start, len=2, bytes 12 34 56 78 9A BC DE F0, checksum 38 → two writes (addr 0 = 12345678, addr 1 = 9ABCDEF0), each IM_wr_en pulse 1 cycle after its 4th byte. Then done=1, cpu_rst=0, busy=0.
- Bad checksum: same stream with checksum 39 → both words are still written; then load_err=1, cpu_rst=1, done=0. A following start plus the good stream → DONE.
- Stalls: same stream with in_valid low on every other cycle → identical writes and addresses, and done=1.
- Abort: assert rst after 5 bytes → the word-1 write never occurs. Restart with the good stream → both words written and done=1.
- Edge and ignored events: start with len=0 → done=1 on the next edge with no IM_wr_en. A start pulse mid-LOAD → no effect on the address or the byte count.
